icache_port_arbiter: RTL and testbench
======================================

// Module: icache_port_arbiter
// PURPOSE
//  Shares the single instruction-cache read port between two requesters: port 0 (IFQ fetch, priority)
//  and port 1 (secondary reader: prefetch/debug). Sits between the requesters and i_cache.
//  Allows one outstanding cache read at a time and forwards per-owner aborts.
//  Has a starvation guard for port 1 and a watchdog that aborts hung reads.
// PARAMETERS
//  ADDR_W      32   cache read address width (pc_in)
//  DATA_W      128  cache line width (Dout; 4 x 32b instructions)
//  STARVE_MAX  4    consecutive port-0 grants while port 1 waits before port 1 is forced
//  TIMEOUT     64   BUSY cycles without Dout_valid before the watchdog aborts (>=2)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  req0_valid      in   1       port 0 read request
//  req0_addr       in   ADDR_W  port 0 read address
//  req0_ready      out  1       port 0 request accepted this cycle
//  req0_abort      in   1       port 0 cancels its outstanding read
//  resp0_valid     out  1       port 0 response pulse
//  resp0_err       out  1       with resp0_valid: watchdog timeout, data invalid
//  req1_*/resp1_*  -    -       identical set for port 1
//  resp_data       out  DATA_W  shared response data (= cache_dout)
//  cache_pc        out  ADDR_W  to i_cache pc_in
//  cache_rd_en     out  1       to i_cache rd_en
//  cache_abort     out  1       to i_cache abort
//  cache_dout      in   DATA_W  from i_cache Dout
//  cache_dout_valid in  1       from i_cache Dout_valid
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, starve_cnt=0, wdog_cnt=0, addr reg=0.
//    All outputs are 0, except resp_data, which passes cache_dout through.
//  - States: IDLE (no read outstanding), BUSY (read to owner outstanding).
//  - In BUSY, cache_rd_en=1 and cache_pc=latched address, held stable until completion or abort.
//    In IDLE, cache_rd_en=0.
//  - Grant (IDLE, or the BUSY completion cycle):
//    - Port 1 wins if req1_valid and (!req0_valid or starve_cnt==STARVE_MAX); otherwise port 0
//      wins if req0_valid.
//    - reqN_ready is combinational, in the same cycle.
//    - Address and owner are latched; next state is BUSY; wdog_cnt clears to 0.
//  - starve_cnt:
//    - +1 on each port-0 grant while req1_valid=1 (saturates at STARVE_MAX).
//    - Clears on a port-1 grant or whenever req1_valid=0.
//  - Completion: BUSY & cache_dout_valid & no abort this cycle.
//    - respN_valid=1 for owner N only, for 1 cycle, combinationally.
//    - Next state is IDLE, unless a new grant is made in this same cycle (back-to-back, zero bubble).
//  - Owner abort: BUSY & reqN_abort & owner==N.
//    - cache_abort=1 this cycle; no respN_valid even if cache_dout_valid=1.
//    - No new grant this cycle; next state is IDLE.
//    - reqN_abort from a non-owner, or in IDLE, is ignored.
//  - Watchdog: wdog_cnt counts BUSY cycles. When wdog_cnt==TIMEOUT-1 and no dout_valid and no abort:
//    - cache_abort=1 and respN_valid=1 with respN_err=1 for the owner.
//    - Next state is IDLE; no grant this cycle.
//  - Priority in one cycle: owner abort > completion > watchdog.
//    A completion arriving on the timeout cycle is a normal completion.
//  - Reset asserted mid-BUSY: returns immediately to IDLE. No cache_abort is issued; the cache is
//    reset by the same rst.
//  - ready/resp outputs are never asserted on both ports in the same cycle.
// STRUCTURE
//  - Shared package ifq_pkg:
//    - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t
//    - typedef enum logic {OWN_IFQ, OWN_AUX} arb_owner_t
//    - localparams IFQ_ADDR_W=32, IFQ_LINE_W=128
//  - One sub-module, icache_arb_wdog:
//    - TIMEOUT-parameterised counter with clear/enable inputs and an expire output.
//  - The grant/FSM/starvation logic stays in the top.
// TESTING
//  - Reset: rst=1 mid-BUSY -> next edge IDLE, cache_rd_en=0, all ready/resp=0.
//    After release, req0 @0x100 is granted.
//  - Single read: req0 @0x100, cache returns 3 cycles later ->
//    - req0_ready in cycle 0; cache_rd_en=1 with cache_pc=0x100 for cycles 1-3.
//    - resp0_valid pulse in cycle 3 with resp_data=cache_dout.
//  - Starvation: req0 always valid, req1 @0x200 valid, 1-cycle cache ->
//    4 port-0 grants, then the 5th grant goes to port 1 (resp1_valid); starve_cnt returns to 0.
//  - Back-to-back: req0 @0x100 completes while req1 @0x200 is waiting ->
//    req1_ready in the completion cycle; cache_pc=0x200 on the next cycle, no bubble.
//  - Abort: port 0 BUSY, req0_abort asserted together with cache_dout_valid ->
//    cache_abort=1, no resp0_valid, IDLE next cycle. req1_abort while port 0 owns -> ignored.
//  - Watchdog: TIMEOUT=8, cache never responds ->
//    cycle 8 after the grant shows cache_abort=1, resp0_valid=1, resp0_err=1, then IDLE.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and widths for the instruction-fetch side: arbiter state and read-port owner.
package ifq_pkg;

  localparam int IFQ_ADDR_W = 32;
  localparam int IFQ_LINE_W = 128;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_IFQ, OWN_AUX} arb_owner_t;

endpackage

// File: rtl/icache_port_arbiter_if.sv
// Bundle between the two cache-port requesters plus the i_cache, and the arbiter in between.
// master = requesters and cache (the environment), slave = the arbiter.
interface icache_port_arbiter_if import ifq_pkg::*; #(
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int DATA_W = IFQ_LINE_W
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req0_abort;
  logic              resp0_valid;
  logic              resp0_err;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              req1_abort;
  logic              resp1_valid;
  logic              resp1_err;

  logic [DATA_W-1:0] resp_data;

  logic [ADDR_W-1:0] cache_pc;
  logic              cache_rd_en;
  logic              cache_abort;
  logic [DATA_W-1:0] cache_dout;
  logic              cache_dout_valid;

  modport master (
    output req0_valid, req0_addr, req0_abort,
    output req1_valid, req1_addr, req1_abort,
    output cache_dout, cache_dout_valid,
    input  req0_ready, resp0_valid, resp0_err,
    input  req1_ready, resp1_valid, resp1_err,
    input  resp_data, cache_pc, cache_rd_en, cache_abort
  );

  modport slave (
    input  req0_valid, req0_addr, req0_abort,
    input  req1_valid, req1_addr, req1_abort,
    input  cache_dout, cache_dout_valid,
    output req0_ready, resp0_valid, resp0_err,
    output req1_ready, resp1_valid, resp1_err,
    output resp_data, cache_pc, cache_rd_en, cache_abort
  );

endinterface

// File: rtl/icache_arb_wdog.sv
// Watchdog for the outstanding cache read: counts busy cycles and flags the last allowed one.
module icache_arb_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Holds at TIMEOUT-1 once reached; the owner of the read is aborted on that cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/icache_port_arbiter.sv
// Shares the single i_cache read port between the IFQ fetch (port 0, priority) and an auxiliary
// reader (port 1), one outstanding read at a time, with starvation guard and hung-read watchdog.
module icache_port_arbiter import ifq_pkg::*; #(
  parameter int ADDR_W     = IFQ_ADDR_W,
  parameter int DATA_W     = IFQ_LINE_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  arb_owner_t        owner;
  logic [ADDR_W-1:0] addr_q;
  logic [SW-1:0]     starve_cnt;
  logic [DATA_W-1:0] line_data;

  logic busy, own_abort, complete, timeout, wdog_expire;
  logic grant_ok, starved, grant0, grant1;

  assign busy      = (state == ARB_BUSY);
  assign own_abort = busy && ((owner == OWN_IFQ) ? bus.req0_abort : bus.req1_abort);
  assign complete  = busy && bus.cache_dout_valid && !own_abort;
  assign timeout   = busy && wdog_expire && !bus.cache_dout_valid && !own_abort;

  // Gating with rst keeps ready low while the async reset is held, even with requests pending.
  assign grant_ok = !rst && (!busy || complete);
  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign grant1   = grant_ok && bus.req1_valid && (!bus.req0_valid || starved);
  assign grant0   = grant_ok && bus.req0_valid && !grant1;

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = (complete || timeout) && (owner == OWN_IFQ);
  assign bus.resp1_valid = (complete || timeout) && (owner == OWN_AUX);
  assign bus.resp0_err   = timeout && (owner == OWN_IFQ);
  assign bus.resp1_err   = timeout && (owner == OWN_AUX);
  assign bus.cache_abort = own_abort || timeout;
  assign bus.cache_rd_en = busy;
  assign bus.cache_pc    = addr_q;

  assign line_data     = bus.cache_dout;
  assign bus.resp_data = line_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IFQ;
      addr_q     <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant0 || grant1) begin
        state  <= ARB_BUSY;
        owner  <= grant1 ? OWN_AUX : OWN_IFQ;
        addr_q <= grant1 ? bus.req1_addr : bus.req0_addr;
      end else if (own_abort || complete || timeout) begin
        state <= ARB_IDLE;
      end

      // Counts port-0 wins only while port 1 is actually waiting.
      if (!bus.req1_valid || grant1) begin
        starve_cnt <= '0;
      end else if (grant0 && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  icache_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant0 || grant1),
    .enable (busy),
    .expire (wdog_expire)
  );

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Bench for icache_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration rules.
module tb_icache_port_arbiter;
  import ifq_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  icache_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          v0;
    logic [31:0] a0;
    bit          ab0;
    bit          v1;
    logic [31:0] a1;
    bit          ab1;
    bit          dv;
  } stim_t;

  typedef struct {
    logic        rdy0, rdy1, rv0, re0, rv1, re1, rd_en, abort;
    logic [31:0] pc;
    logic [127:0] data;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the outstanding read as a transaction (owner, address, age) plus the
  // number of consecutive port-0 wins seen by a waiting port 1.
  bit          m_busy   = 1'b0;
  int          m_owner  = 0;
  logic [31:0] m_addr   = '0;
  int          m_age    = 0;
  int          m_starve = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{v0: 1'b0, a0: '0, ab0: 1'b0, v1: 1'b0, a1: '0, ab1: 1'b0, dv: 1'b0};
    return s;
  endfunction

  // Drives one cycle of stimulus just after the rising edge, samples at the falling edge,
  // compares against the model, then advances the model across the next rising edge.
  task automatic cycle(input stim_t s, output obs_t o);
    logic [127:0] dout;
    obs_t e;
    bit   r, can_grant, stay_busy, own_ab;
    int   gnt;
    dout = {$urandom, $urandom, $urandom, $urandom};
    bus.req0_valid = s.v0;  bus.req0_addr = s.a0;  bus.req0_abort = s.ab0;
    bus.req1_valid = s.v1;  bus.req1_addr = s.a1;  bus.req1_abort = s.ab1;
    bus.cache_dout_valid = s.dv;
    bus.cache_dout = dout;
    @(negedge clk);
    o = '{rdy0: bus.req0_ready, rdy1: bus.req1_ready, rv0: bus.resp0_valid, re0: bus.resp0_err,
          rv1: bus.resp1_valid, re1: bus.resp1_err, rd_en: bus.cache_rd_en,
          abort: bus.cache_abort, pc: bus.cache_pc, data: bus.resp_data};

    e = '{default: '0};
    e.data = dout;
    r = rst;
    gnt = -1;
    can_grant = 1'b0;
    stay_busy = 1'b0;
    if (!r) begin
      e.rd_en = m_busy;
      e.pc    = m_addr;
      if (m_busy) begin
        own_ab = (m_owner == 0) ? s.ab0 : s.ab1;
        if (own_ab) begin
          e.abort = 1'b1;
        end else if (s.dv) begin
          if (m_owner == 0) e.rv0 = 1'b1; else e.rv1 = 1'b1;
          can_grant = 1'b1;
        end else if (m_age == TMO - 1) begin
          e.abort = 1'b1;
          if (m_owner == 0) begin e.rv0 = 1'b1; e.re0 = 1'b1; end
          else              begin e.rv1 = 1'b1; e.re1 = 1'b1; end
        end else begin
          stay_busy = 1'b1;
        end
      end else begin
        can_grant = 1'b1;
      end
      if (can_grant) begin
        if (s.v1 && (!s.v0 || m_starve == SMAX)) gnt = 1;
        else if (s.v0)                           gnt = 0;
      end
      e.rdy0 = (gnt == 0);
      e.rdy1 = (gnt == 1);
    end

    check("ready0", o.rdy0, e.rdy0);
    check("ready1", o.rdy1, e.rdy1);
    check("resp0_valid", o.rv0, e.rv0);
    check("resp0_err", o.re0, e.re0);
    check("resp1_valid", o.rv1, e.rv1);
    check("resp1_err", o.re1, e.re1);
    check("cache_rd_en", o.rd_en, e.rd_en);
    check("cache_abort", o.abort, e.abort);
    check("resp_data", o.data, e.data);
    if (r || m_busy) check("cache_pc", o.pc, r ? 32'h0 : e.pc);

    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 1'b0; m_owner = 0; m_addr = '0; m_age = 0; m_starve = 0;
    end else begin
      if (!s.v1 || gnt == 1)               m_starve = 0;
      else if (gnt == 0 && m_starve < SMAX) m_starve++;
      if (gnt >= 0) begin
        m_busy = 1'b1; m_owner = gnt; m_addr = (gnt == 1) ? s.a1 : s.a0; m_age = 0;
      end else if (stay_busy) begin
        m_age++;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  initial begin
    stim_t s;
    obs_t  o;

    // Reset state
    rst = 1'b1;
    s = idle_s();
    repeat (2) cycle(s, o);
    check("reset_rd_en", o.rd_en, 0);
    rst = 1'b0;

    // Single read, cache answers in the third busy cycle
    s = idle_s(); s.v0 = 1; s.a0 = 32'h100;
    cycle(s, o);
    check("single_ready0", o.rdy0, 1);
    s = idle_s();
    for (int i = 1; i <= 2; i++) begin
      cycle(s, o);
      check("single_pc", o.pc, 32'h100);
      check("single_rd_en", o.rd_en, 1);
    end
    s.dv = 1;
    cycle(s, o);
    check("single_resp0", o.rv0, 1);

    // Starvation guard, run twice to see the counter start over
    for (int rep = 0; rep < 2; rep++) begin
      s = idle_s(); s.v0 = 1; s.a0 = 32'h100; s.v1 = 1; s.a1 = 32'h200; s.dv = 1;
      for (int i = 0; i < 5; i++) begin
        cycle(s, o);
        check("starve_grant1", o.rdy1, (i == 4));
        check("starve_grant0", o.rdy0, (i != 4));
      end
      s = idle_s(); s.dv = 1;
      cycle(s, o);
      check("starve_resp1", o.rv1, 1);
    end

    // Back-to-back: port 1 granted in port 0's completion cycle
    s = idle_s(); s.v0 = 1; s.a0 = 32'h100;
    cycle(s, o);
    s = idle_s(); s.v1 = 1; s.a1 = 32'h200;
    cycle(s, o);
    check("b2b_wait_ready1", o.rdy1, 0);
    s.dv = 1;
    cycle(s, o);
    check("b2b_resp0", o.rv0, 1);
    check("b2b_ready1", o.rdy1, 1);
    s = idle_s();
    cycle(s, o);
    check("b2b_pc", o.pc, 32'h200);
    check("b2b_rd_en", o.rd_en, 1);
    s.dv = 1;
    cycle(s, o);
    check("b2b_resp1", o.rv1, 1);

    // Aborts: non-owner ignored, owner abort beats completion and blocks grants
    s = idle_s(); s.v0 = 1; s.a0 = 32'h300;
    cycle(s, o);
    s = idle_s(); s.ab1 = 1;
    cycle(s, o);
    check("abort_nonowner", o.abort, 0);
    s = idle_s(); s.ab0 = 1; s.dv = 1; s.v1 = 1; s.a1 = 32'h200;
    cycle(s, o);
    check("abort_owner", o.abort, 1);
    check("abort_no_resp0", o.rv0, 0);
    check("abort_no_grant", o.rdy1, 0);
    s = idle_s(); s.ab0 = 1;
    cycle(s, o);
    check("abort_idle_rd_en", o.rd_en, 0);
    check("abort_idle_ignored", o.abort, 0);

    // Watchdog expiry, then a completion landing on the timeout cycle
    s = idle_s(); s.v0 = 1; s.a0 = 32'h400;
    cycle(s, o);
    s = idle_s();
    for (int i = 1; i <= TMO; i++) begin
      cycle(s, o);
      if (i == TMO) begin
        check("wdog_abort", o.abort, 1);
        check("wdog_resp0", o.rv0, 1);
        check("wdog_err0", o.re0, 1);
      end else begin
        check("wdog_quiet", o.abort, 0);
      end
    end
    cycle(s, o);
    check("wdog_idle", o.rd_en, 0);
    s = idle_s(); s.v1 = 1; s.a1 = 32'h440;
    cycle(s, o);
    s = idle_s();
    for (int i = 1; i < TMO; i++) cycle(s, o);
    s.dv = 1;
    cycle(s, o);
    check("wdog_late_resp1", o.rv1, 1);
    check("wdog_late_err1", o.re1, 0);
    check("wdog_late_abort", o.abort, 0);

    // Reset while busy
    s = idle_s(); s.v0 = 1; s.a0 = 32'h500;
    cycle(s, o);
    s = idle_s();
    cycle(s, o);
    rst = 1'b1;
    s = idle_s(); s.v0 = 1; s.a0 = 32'h600; s.v1 = 1; s.a1 = 32'h700;
    cycle(s, o);
    check("rst_busy_rd_en", o.rd_en, 0);
    check("rst_busy_ready0", o.rdy0, 0);
    check("rst_busy_ready1", o.rdy1, 0);
    check("rst_busy_abort", o.abort, 0);
    rst = 1'b0;
    s = idle_s(); s.v0 = 1; s.a0 = 32'h100;
    cycle(s, o);
    check("rst_after_ready0", o.rdy0, 1);
    s = idle_s();
    cycle(s, o);
    check("rst_after_pc", o.pc, 32'h100);
    s.dv = 1;
    cycle(s, o);

    // Randomized traffic; every fourth block starves the cache so timeouts occur
    for (int n = 0; n < 2000; n++) begin
      s.v0  = ($urandom_range(0, 9) < 6);
      s.a0  = $urandom;
      s.ab0 = ($urandom_range(0, 19) == 0);
      s.v1  = ($urandom_range(0, 9) < 5);
      s.a1  = $urandom;
      s.ab1 = ($urandom_range(0, 19) == 0);
      if (((n / 100) % 4) == 3) s.dv = ($urandom_range(0, 29) == 0);
      else                      s.dv = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle(s, o);
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
